// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point class codes, divider FSM states and exponent constants
package fp_pkg;

    localparam logic [2:0] st_NORM = 3'd0;
    localparam logic [2:0] st_ZERO = 3'd1;
    localparam logic [2:0] st_SUBN = 3'd2;
    localparam logic [2:0] st_INF  = 3'd3;
    localparam logic [2:0] st_NAN  = 3'd4;

    typedef enum logic [1:0] {sIdle, sDiv, sRound, sDone} divState_t;

    function automatic int fBias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    function automatic int fExpOnes(input int expW);
        return (1 << expW) - 1;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE754 operand class decode (sign excluded)
module fp_classify
    import fp_pkg::*;
#(
    parameter int pExpW = 8,
    parameter int pManW = 23
) (
    input  logic [pExpW+pManW-1:0] iv_Op,
    output logic [2:0]             ov_Class
);

    // all-ones exponent is INF/NAN, zero exponent is ZERO/SUBN, anything else is normal
    always_comb begin
        ov_Class = (&iv_Op[pExpW+pManW-1:pManW]) ? ((|iv_Op[pManW-1:0]) ? st_NAN : st_INF) :
                   (~|iv_Op[pExpW+pManW-1:pManW]) ? ((|iv_Op[pManW-1:0]) ? st_SUBN : st_ZERO) : st_NORM;
    end

endmodule

// File: rtl/fp_div.sv
// fp_div: multi-cycle IEEE754 divider, restoring radix-2; define FP_DIV_RNE_EN for round-to-nearest-even, else truncate
module fp_div
    import fp_pkg::*;
#(
    parameter int pPrecision = 1,
    parameter int pWidthExp  = 8,
    parameter int pWidthMan  = 23,
    localparam int pExpW = (pPrecision == 1) ? 8 : (pPrecision == 2) ? 11 : pWidthExp,
    localparam int pManW = (pPrecision == 1) ? 23 : (pPrecision == 2) ? 52 : pWidthMan,
    localparam int W     = pExpW + pManW + 1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_ClkEn,
    input  logic         i_Dv,
    output logic         o_Ready,
    input  logic [W-1:0] iv_InputA,
    input  logic [W-1:0] iv_InputB,
    output logic         o_Dv,
    output logic [W-1:0] ov_Result,
    output logic         o_Overflow,
    output logic         o_Underflow,
    output logic         o_NAN,
    output logic         o_PINF,
    output logic         o_NINF,
    output logic         o_DivByZero
);

    localparam int pIter = pManW + 3;
    localparam int pCntW = $clog2(pIter);
    localparam logic signed [pExpW+1:0] cBias = (pExpW + 2)'(fBias(pExpW));
    localparam logic signed [pExpW+1:0] cOnes = (pExpW + 2)'(fExpOnes(pExpW));

    divState_t stateQ, stateD;
    logic [2:0] clsA, clsB;
    logic zeroA, zeroB, infA, infB, spNan, spInf, spZero;
    logic [pCntW-1:0] cntQ;
    logic [pManW+1:0] remQ;
    logic [pManW:0] divQ, remSub;
    logic remGe;
    logic [pIter-1:0] quoQ;
    logic signed [pExpW+1:0] expQ, expF;
    logic signQ, nanQ, infQ, zeroQ, dbzQ, subnQ;
    logic norm, inc, ovf, unf, resInf;
    logic [pManW-1:0] manT, manR;
    logic [W-1:0] resD;

    fp_classify #(.pExpW(pExpW), .pManW(pManW)) uClassA (.iv_Op(iv_InputA[W-2:0]), .ov_Class(clsA));
    fp_classify #(.pExpW(pExpW), .pManW(pManW)) uClassB (.iv_Op(iv_InputB[W-2:0]), .ov_Class(clsB));

    // special-case decision at accept; subnormals are flushed to zero
    always_comb begin
        zeroA  = clsA == st_ZERO || clsA == st_SUBN;
        zeroB  = clsB == st_ZERO || clsB == st_SUBN;
        infA   = clsA == st_INF;
        infB   = clsB == st_INF;
        spNan  = clsA == st_NAN || clsB == st_NAN || (zeroA && zeroB) || (infA && infB);
        spInf  = !spNan && (zeroB || infA);
        spZero = !spNan && !spInf && (zeroA || infB);
    end

    // one restoring-division step, then normalize/round/pack the finished quotient
    always_comb begin
        remGe  = remQ >= {1'b0, divQ};
        remSub = remQ[pManW:0] - divQ;
        norm   = quoQ[pIter-1];
        manT   = norm ? quoQ[pIter-2:2] : quoQ[pIter-3:1];
`ifdef FP_DIV_RNE_EN
        inc    = norm ? quoQ[1] && (quoQ[0] || (|remQ) || manT[0]) : quoQ[0] && ((|remQ) || manT[0]);
`else
        inc    = 1'b0;
`endif
        manR   = manT + pManW'(inc);
        expF   = expQ - (pExpW + 2)'(!norm) + (pExpW + 2)'(inc && (&manT));
        ovf    = !(nanQ || infQ || zeroQ) && !expF[pExpW+1] && expF >= cOnes;
        unf    = !(nanQ || infQ || zeroQ) && (expF[pExpW+1] || expF == '0);
        resInf = infQ || ovf;
        resD   = nanQ ? {1'b0, {pExpW{1'b1}}, 1'b1, {(pManW - 1){1'b0}}} :
                 resInf ? {signQ, {pExpW{1'b1}}, {pManW{1'b0}}} :
                 (zeroQ || unf) ? {signQ, {(W - 1){1'b0}}} : {signQ, expF[pExpW-1:0], manR};
    end

    // next state; handshake outputs decode straight from the state
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            sIdle:   stateD = i_Dv ? sDiv : sIdle;
            sDiv:    stateD = (cntQ == pCntW'(pIter - 1)) ? sRound : sDiv;
            sRound:  stateD = sDone;
            default: stateD = sIdle;
        endcase
        o_Ready = stateQ == sIdle;
        o_Dv    = stateQ == sDone;
    end

    // control state and registered results; reset overrides the clock enable
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            stateQ      <= sIdle;
            ov_Result   <= '0;
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
            o_NAN       <= 1'b0;
            o_PINF      <= 1'b0;
            o_NINF      <= 1'b0;
            o_DivByZero <= 1'b0;
        end else if (i_ClkEn) begin
            stateQ <= stateD;
            if (stateQ == sRound) begin
                ov_Result   <= resD;
                o_Overflow  <= ovf;
                o_Underflow <= unf || subnQ;
                o_NAN       <= nanQ;
                o_PINF      <= resInf && !signQ;
                o_NINF      <= resInf && signQ;
                o_DivByZero <= dbzQ;
            end
        end
    end

    // operand capture on accept and one quotient bit per enabled DIV cycle
    always_ff @(posedge i_Clk) begin
        if (i_ClkEn) begin
            if (stateQ == sIdle && i_Dv) begin
                cntQ  <= '0;
                remQ  <= {2'b01, iv_InputA[pManW-1:0]};
                divQ  <= {1'b1, iv_InputB[pManW-1:0]};
                expQ  <= $signed({2'b00, iv_InputA[W-2:pManW]}) - $signed({2'b00, iv_InputB[W-2:pManW]}) + cBias;
                signQ <= iv_InputA[W-1] ^ iv_InputB[W-1];
                nanQ  <= spNan;
                infQ  <= spInf;
                zeroQ <= spZero;
                dbzQ  <= !spNan && zeroB && !infA;
                subnQ <= clsA == st_SUBN || clsB == st_SUBN;
            end
            if (stateQ == sDiv) begin
                cntQ <= cntQ + pCntW'(1);
                remQ <= {remGe ? remSub : remQ[pManW:0], 1'b0};
                quoQ <= {quoQ[pIter-2:0], remGe};
            end
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: table-driven scoreboard bench for fp_div (single precision); honours FP_DIV_RNE_EN
module tb_fp_div;

    logic clk = 1'b0, rst = 1'b1, clkEn = 1'b1, dv = 1'b0;
    logic ready, outDv, ovf, unf, nan, pinf, ninf, dbz;
    logic [31:0] a = '0, b = '0, result;
    logic [5:0] flagsV;
    int cyc = 0, tests = 0, fails = 0;
    logic prevDv = 1'b0;

    typedef struct { logic [31:0] res; logic [5:0] fl; int acc; int lat; int id; } sb_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [5:0] fl; } vec_t;
    sb_t sbq[$];
    sb_t e;
    vec_t vecs[$];

`ifdef FP_DIV_RNE_EN
    localparam logic [31:0] cThird = 32'h3EAAAAAB, cTwoThird = 32'h3F2AAAAB, cNearOne = 32'h3F800001;
`else
    localparam logic [31:0] cThird = 32'h3EAAAAAA, cTwoThird = 32'h3F2AAAAA, cNearOne = 32'h3F800000;
`endif

    fp_div dut (
        .i_Clk(clk), .i_Rst(rst), .i_ClkEn(clkEn), .i_Dv(dv), .o_Ready(ready),
        .iv_InputA(a), .iv_InputB(b), .o_Dv(outDv), .ov_Result(result),
        .o_Overflow(ovf), .o_Underflow(unf), .o_NAN(nan), .o_PINF(pinf),
        .o_NINF(ninf), .o_DivByZero(dbz)
    );

    assign flagsV = {ovf, unf, nan, pinf, ninf, dbz};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every rising o_Dv pops one expected result and checks value, flags and latency
    always @(negedge clk) begin
        if (outDv && !prevDv) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_dv: o_Dv=1 result=%h, required no output", result);
            end else begin
                e = sbq.pop_front();
                if (result !== e.res || flagsV !== e.fl) begin
                    fails++;
                    $display("FAIL vec%0d result: got %h flags %b, required %h flags %b", e.id, result, flagsV, e.res, e.fl);
                end
                tests++;
                if (cyc - e.acc + 1 != e.lat) begin
                    fails++;
                    $display("FAIL vec%0d latency: got %0d, required %0d", e.id, cyc - e.acc + 1, e.lat);
                end
            end
        end
        prevDv = outDv;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic startOp(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] res,
                           input logic [5:0] fl, input int lat, input int id, input bit push);
        @(negedge clk);
        a = va;
        b = vb;
        dv = 1'b1;
        if (push) sbq.push_back('{res, fl, cyc + 1, lat, id});
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int n;
        int dvSeen;
        // flags order {ovf, unf, nan, pinf, ninf, dbz}
        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 6'b000000});
        vecs.push_back('{32'h3F800000, 32'h40400000, cThird,       6'b000000});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 6'b000101});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 6'b001000});
        vecs.push_back('{32'hBF800000, 32'h7F800000, 32'h80000000, 6'b000000});
        vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 6'b100100});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 6'b010000});
        vecs.push_back('{32'hC0C00000, 32'h40000000, 32'hC0400000, 6'b000000});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 6'b010000});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 6'b001000});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 6'b001000});
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 6'b000010});
        vecs.push_back('{32'hBF800000, 32'h80000000, 32'h7F800000, 6'b000101});
        vecs.push_back('{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 6'b000000});
        vecs.push_back('{32'h3F800000, 32'h3FC00000, cTwoThird,    6'b000000});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 6'b000000});
        vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, cNearOne,     6'b000000});
        vecs.push_back('{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 6'b000000});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_dv", 64'(outDv), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(flagsV), 64'd0);

        foreach (vecs[i]) begin
            startOp(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, 28, i, 1'b1);
            waitDone();
        end

        // i_Dv held high: second operation may only be accepted on the cycle after DONE
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        dv = 1'b1;
        sbq.push_back('{32'h40400000, 6'b000000, cyc + 1, 28, 100});
        @(negedge clk);
        check("ready_busy", 64'(ready), 64'd0);
        a = 32'h3FC00000;
        b = 32'h3F800000;
        sbq.push_back('{32'h3FC00000, 6'b000000, cyc + 29, 28, 101});
        repeat (29) @(negedge clk);
        dv = 1'b0;
        waitDone();

        // clock enable low for 5 cycles in the middle of DIV
        startOp(32'h3F800000, 32'h40400000, cThird, 6'b000000, 33, 102, 1'b1);
        repeat (8) @(negedge clk);
        clkEn = 1'b0;
        repeat (5) @(negedge clk);
        clkEn = 1'b1;
        waitDone();

        // o_Dv must stay high while frozen in DONE
        startOp(32'hC0C00000, 32'h40000000, 32'hC0400000, 6'b000000, 28, 103, 1'b1);
        n = 0;
        while (!outDv && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 64'(outDv), 64'd1);
        clkEn = 1'b0;
        repeat (3) @(negedge clk);
        check("done_hold_dv", 64'(outDv), 64'd1);
        check("done_hold_result", 64'(result), 64'hC0400000);
        clkEn = 1'b1;
        @(negedge clk);
        check("done_release_dv", 64'(outDv), 64'd0);
        check("done_release_ready", 64'(ready), 64'd1);

        // reset pulsed mid-division aborts the operation and clears outputs
        startOp(32'h3F800000, 32'h00000000, 32'h0, 6'b0, 28, 104, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags", 64'(flagsV), 64'd0);
        dvSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (outDv) dvSeen++;
        end
        check("abort_no_dv", 64'(dvSeen), 64'd0);
        startOp(32'h40C00000, 32'h40000000, 32'h40400000, 6'b000000, 28, 105, 1'b1);
        waitDone();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameter pPrecision, default 1, meaning 0 custom, 1 single, 2 double.
REQ-002 SHALL have parameters pWidthExp, default 8, and pWidthMan, default 23: exponent and mantissa widths, used only when pPrecision=0.
REQ-003 SHALL derive pExpW/pManW as 8/23 (pPrecision=1), 11/52 (pPrecision=2), else pWidthExp/pWidthMan; word width W=pExpW+pManW+1.
REQ-004 SHALL have ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  reset; one clock, synchronous, active-high.
- i_ClkEn  in  1  global stall; when low all state holds.
- i_Dv  in  1  operands valid.
- o_Ready  out  1  idle, can accept.
- iv_InputA  in  W  dividend, IEEE754 layout.
- iv_InputB  in  W  divisor, IEEE754 layout.
- o_Dv  out  1  result valid, one-cycle pulse.
- ov_Result  out  W  quotient A/B.
- o_Overflow, o_Underflow, o_NAN, o_PINF, o_NINF, o_DivByZero  out  1 each  status, valid with o_Dv.

Function
REQ-005 SHALL accept operands on a rising edge with i_ClkEn=1, i_Dv=1 and o_Ready=1; i_Dv while o_Ready=0 SHALL be ignored.
REQ-006 SHALL implement FSM IDLE -> DIV -> ROUND -> DONE -> IDLE; o_Ready=1 only in IDLE.
REQ-007 SHALL, on accept, classify each operand: ZERO, SUBN, NORM, INF or NAN; SUBN SHALL be treated as ZERO (flush) and SHALL set o_Underflow.
REQ-008 SHALL compute the exponent as Ea-Eb+bias in a pExpW+2-bit signed register.
REQ-009 SHALL compute sign as signA XOR signB for all results, including zero and inf.
REQ-010 SHALL, in DIV, run restoring radix-2 division of {1,manA} by {1,manB}, one quotient bit per cycle, for exactly pManW+3 cycles.
REQ-011 SHALL form the sticky bit as OR-reduction of the final remainder.
REQ-012 SHALL, in ROUND (1 cycle):
- normalize: if quotient MSB=0, shift left 1 and decrement exponent;
- round per REQ-021/022; a mantissa carry-out SHALL increment the exponent.
REQ-013 SHALL assert o_Dv in DONE for one cycle, exactly pManW+5 enabled cycles after the accepting edge (28 for single), independent of operand class.
REQ-014 SHALL hold ov_Result and flags stable after DONE until the next o_Dv.
REQ-015 SHALL apply special cases in priority order:
- any NAN, 0/0 or inf/inf -> quiet NaN (exp all 1s, mantissa MSB 1), o_NAN=1;
- finite/0 -> signed inf, o_DivByZero=1;
- inf/finite -> signed inf;
- 0/x or finite/inf -> signed zero.
REQ-016 SHALL, when the final exponent >= 2^pExpW-1, output signed inf with o_Overflow=1.
REQ-017 SHALL, when the final exponent <= 0, output signed zero with o_Underflow=1.
REQ-018 SHALL drive o_PINF=o_Overflow&~sign and o_NINF=o_Overflow&sign; inf results from REQ-015 SHALL also set o_PINF/o_NINF.
REQ-019 SHALL, while i_ClkEn=0, freeze the FSM, iteration counter and datapath; o_Dv SHALL stay high if held in DONE.

Reset
REQ-020 SHALL, on i_Rst=1 (overrides i_ClkEn), within one cycle:
- go to IDLE and abort any in-flight division;
- set o_Ready=1 and o_Dv=0;
- clear ov_Result to 0 and all flags to 0.

Configuration
REQ-021 SHALL, with macro FP_DIV_RNE_EN defined, round to nearest even using guard, round and sticky bits.
REQ-022 SHALL, without FP_DIV_RNE_EN, truncate (round toward zero); ROUND state and latency are unchanged.

Structure
REQ-023 SHALL take from shared package fp_pkg: class encodings st_NORM=0, st_ZERO=1, st_SUBN=2, st_INF=3, st_NAN=4; FSM state typedef; bias and exponent-all-ones constants as functions of pExpW.
REQ-024 SHALL instantiate one combinational sub-module fp_classify, used twice (A and B), returning the 3-bit class.

Verification
REQ-025 Single precision: 0x40C00000 / 0x40000000 -> 0x40400000, o_Dv exactly 28 cycles after accept, all flags 0.
REQ-026 Rounding: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB with FP_DIV_RNE_EN; 0x3EAAAAAA without.
REQ-027 Specials:
- 0x3F800000 / 0x00000000 -> 0x7F800000, o_DivByZero=1, o_PINF=1;
- 0 / 0 -> 0x7FC00000, o_NAN=1;
- 0xBF800000 / 0x7F800000 -> 0x80000000.
REQ-028 Range: 0x7F000000 / 0x3E800000 -> 0x7F800000 with o_Overflow=1; 0x00800000 / 0x40000000 -> 0x00000000 with o_Underflow=1.
REQ-029 Handshake: i_Dv held high across two operations -> second accepted only on the cycle after DONE; i_ClkEn low for 5 cycles mid-DIV -> o_Dv delayed exactly 5 cycles, result unchanged.
REQ-030 Reset: i_Rst pulsed at DIV cycle 10 -> no o_Dv; next cycle o_Ready=1, ov_Result=0; a new operation then completes correctly.
